// File: rtl/a2d_sequencer.sv
// Round-robin scheduler for the four SPI A2D channels (left/right load cell, steering pot, battery).
// Each round issues a command and a read transaction per channel, then flags a coherent sample set.
module a2d_sequencer #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy,
  output logic        a2d_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TmrMax = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GapMax = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCmd     = 3'd1;
  localparam logic [2:0] StWaitCmd = 3'd2;
  localparam logic [2:0] StGap     = 3'd3;
  localparam logic [2:0] StRead    = 3'd4;
  localparam logic [2:0] StWaitRd  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [11:0]   lft_q, rght_q, steer_q, batt_q;
  logic          cap;

  // Sequence slot to A2D mux channel.
  function automatic logic [2:0] chnl_of(input logic [1:0] idx);
    unique case (idx)
      2'd0:    chnl_of = 3'd0;
      2'd1:    chnl_of = 3'd4;
      2'd2:    chnl_of = 3'd5;
      default: chnl_of = 3'd6;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cap     = 1'b0;

    if (nxt && (state_q != StIdle)) pend_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (nxt || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = 2'd0;
          cmd_d   = {2'b00, chnl_of(2'd0), 11'h000};
          state_d = StCmd;
        end
      end
      StCmd: begin
        tmr_d   = '0;
        state_d = StWaitCmd;
      end
      StWaitCmd: begin
        // done wins over a simultaneous timeout expiry
        if (done) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StRead : StGap;
        end else if (tmr_q == TmrMax) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapMax) state_d = StRead;
        else                 gap_d   = gap_q + 1'b1;
      end
      StRead: begin
        tmr_d   = '0;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (done) begin
          cap = 1'b1;
          if (idx_q == 2'd3) begin
            vld_d   = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 2'd1;
            cmd_d   = {2'b00, chnl_of(idx_q + 2'd1), 11'h000};
            state_d = StCmd;
          end
        end else if (tmr_q == TmrMax) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      tmr_q   <= '0;
      gap_q   <= '0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Samples are only touched by their own capture, so an aborted round leaves older ones intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q   <= '0;
      rght_q  <= '0;
      steer_q <= '0;
      batt_q  <= '0;
    end else if (cap) begin
      unique case (idx_q)
        2'd0:    lft_q   <= rd_data[11:0];
        2'd1:    rght_q  <= rd_data[11:0];
        2'd2:    steer_q <= rd_data[11:0];
        default: batt_q  <= rd_data[11:0];
      endcase
    end
  end

  assign wrt       = (state_q == StCmd) || (state_q == StRead);
  assign busy      = (state_q != StIdle);
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign a2d_err   = err_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// Bench for a2d_sequencer: a behavioural SPI/A2D model answers each wrt and tracks the sample set
// the sequencer should be presenting; directed steps exercise triggers, timeouts and reset.
module tb_a2d_sequencer;

  localparam int TIMEOUT = 1024;
  localparam int GAP     = 2;

  logic        clk, rst_n, nxt, done;
  logic [15:0] rd_data;
  logic        wrt, vld, busy, a2d_err;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  a2d_sequencer #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot),
    .batt(batt), .vld(vld), .busy(busy), .a2d_err(a2d_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int          checks, errors;
  int          chan_tab [4] = '{0, 4, 5, 6};
  logic [11:0] exp_smp [4];
  int          txn, last_txn;
  int          vld_cnt, err_cnt, wrt_cnt;
  int          lat_cfg, drop_txn, exact_txn, idle_req, idle_ack;
  bit          rnd_data, gap_spur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI master + A2D model: done arrives lat_cfg cycles after wrt; a transaction is the
  // k-th of its round (0..7), even = command for channel k/2, odd = read of that channel.
  initial begin : spi_model
    int cnt, cur, spur, cyc, done_cyc, rd_done_cyc, drop_cyc;
    bit active, drop_armed, wrt_prev;
    logic [15:0] last_cmd;
    cnt = 0; cur = 0; spur = 0; cyc = 0; done_cyc = 0; rd_done_cyc = 0; drop_cyc = 0;
    active = 0; drop_armed = 0; wrt_prev = 0; last_cmd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      done    = 1'b0;
      rd_data = 16'($urandom);
      if (!rst_n) begin
        txn = 0; last_txn = -1; active = 0; spur = 0; drop_armed = 0; wrt_prev = 0;
        foreach (exp_smp[k]) exp_smp[k] = 12'h000;
      end else begin
        if (idle_req != idle_ack) begin
          idle_ack++;
          done = 1'b1;
        end
        if (spur > 0) begin
          spur--;
          if (spur == 0) done = 1'b1;
        end
        if (active) begin
          cnt--;
          if (cnt == 0) begin
            active = 0;
            done   = 1'b1;
            if (!rnd_data) rd_data = 16'hF000 | 16'(chan_tab[cur/2] * 'h111);
            if (cur % 2 == 1) begin
              exp_smp[cur/2] = rd_data[11:0];
              rd_done_cyc    = cyc;
            end else begin
              done_cyc = cyc;
              if (gap_spur) spur = 1;
            end
          end
        end
        if (vld) begin
          vld_cnt++;
          chk("vld_latency", 32'(cyc - rd_done_cyc), 32'd1);
          chk("vld_lft_ld", 32'(lft_ld), 32'(exp_smp[0]));
          chk("vld_rght_ld", 32'(rght_ld), 32'(exp_smp[1]));
          chk("vld_steer_pot", 32'(steer_pot), 32'(exp_smp[2]));
          chk("vld_batt", 32'(batt), 32'(exp_smp[3]));
        end
        if (a2d_err) begin
          err_cnt++;
          chk("err_expected", 32'(drop_armed), 32'd1);
          chk("err_latency", 32'(cyc - drop_cyc), 32'(TIMEOUT + 1));
          drop_armed = 0;
        end
        if (wrt) begin
          chk("wrt_one_cycle", 32'(wrt_prev), 32'd0);
          wrt_cnt++;
          if (txn % 2 == 0) begin
            chk("cmd_word", 32'(cmd), 32'(chan_tab[txn/2] * 2048));
          end else begin
            chk("cmd_held", 32'(cmd), 32'(last_cmd));
            chk("gap_len", 32'(cyc - done_cyc), 32'(GAP + 1));
          end
          last_cmd = cmd;
          cur      = txn;
          last_txn = txn;
          if (txn == drop_txn) begin
            drop_armed = 1;
            drop_cyc   = cyc;
            txn        = 0;
          end else begin
            active = 1;
            cnt    = (txn == exact_txn) ? TIMEOUT : lat_cfg;
            txn    = (txn + 1) % 8;
          end
        end
        wrt_prev = wrt;
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  // which: 0 = vld, 1 = a2d_err, 2 = wrt
  task automatic wait_for(input string tag, input int which, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && vld === 1'b1) || (which == 1 && a2d_err === 1'b1) ||
          (which == 2 && wrt === 1'b1)) begin
        seen = 1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrt"}, 32'(wrt), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_lft"}, 32'(lft_ld), 32'd0);
    chk({tag, "_rght"}, 32'(rght_ld), 32'd0);
    chk({tag, "_steer"}, 32'(steer_pot), 32'd0);
    chk({tag, "_batt"}, 32'(batt), 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(a2d_err), 32'd0);
  endtask

  initial begin : stim
    int v0, e0, w0;
    logic [11:0] old_r, old_s, old_b;
    checks = 0; errors = 0; vld_cnt = 0; err_cnt = 0; wrt_cnt = 0;
    idle_req = 0; idle_ack = 0; lat_cfg = 40; drop_txn = -1; exact_txn = -1;
    rnd_data = 0; gap_spur = 0;
    nxt = 1'b0; rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // Fixed-pattern round, 40-cycle SPI latency.
    v0 = vld_cnt;
    pulse_nxt();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_for("t1_vld_seen", 0, 2000);
    chk("t1_lft", 32'(lft_ld), 32'h000);
    chk("t1_rght", 32'(rght_ld), 32'h444);
    chk("t1_steer", 32'(steer_pot), 32'h555);
    chk("t1_batt", 32'(batt), 32'h666);
    chk("t1_busy_at_vld", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_vld_pulse", 32'(vld), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Stray done in IDLE: nothing starts, nothing captured.
    w0 = wrt_cnt;
    idle_req++;
    repeat (4) @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_wrt", 32'(wrt_cnt - w0), 32'd0);
    chk("t4_idle_rght", 32'(rght_ld), 32'h444);
    chk("t4_idle_vld", 32'(vld_cnt - v0), 32'd1);

    // Stray done during every GAP, random data.
    rnd_data = 1;
    gap_spur = 1;
    lat_cfg  = int'($urandom_range(3, 30));
    pulse_nxt();
    wait_for("t4_gap_vld_seen", 0, 2000);
    gap_spur = 0;

    // Three nxt pulses during a round -> exactly one back-to-back extra round.
    lat_cfg = int'($urandom_range(1, 40));
    v0 = vld_cnt;
    pulse_nxt();
    repeat (5) @(negedge clk);
    pulse_nxt();
    repeat (7) @(negedge clk);
    pulse_nxt();
    pulse_nxt();
    wait_for("t2_vld1_seen", 0, 2000);
    chk("t2_busy_at_vld1", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t2_back_to_back", 32'(busy), 32'd1);
    wait_for("t2_vld2_seen", 0, 2000);
    @(negedge clk);
    chk("t2_no_third", 32'(busy), 32'd0);
    repeat (8 * (lat_cfg + GAP + 4) + 20) @(negedge clk);
    chk("t2_vld_count", 32'(vld_cnt - v0), 32'd2);

    // Withheld done on the right load cell read -> timeout abort; pending dropped too.
    old_r = exp_smp[1]; old_s = exp_smp[2]; old_b = exp_smp[3];
    lat_cfg  = int'($urandom_range(2, 20));
    drop_txn = 3;
    v0 = vld_cnt; e0 = err_cnt;
    pulse_nxt();
    repeat (10) @(negedge clk);
    pulse_nxt();
    wait_for("t3_err_seen", 1, 2000);
    drop_txn = -1;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_lft_new", 32'(lft_ld), 32'(exp_smp[0]));
    chk("t3_rght_kept", 32'(rght_ld), 32'(old_r));
    chk("t3_steer_kept", 32'(steer_pot), 32'(old_s));
    chk("t3_batt_kept", 32'(batt), 32'(old_b));
    w0 = wrt_cnt;
    @(negedge clk);
    chk("t3_err_pulse", 32'(a2d_err), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_pend_cleared", 32'(busy), 32'd0);
    chk("t3_no_wrt", 32'(wrt_cnt - w0), 32'd0);
    chk("t3_no_vld", 32'(vld_cnt - v0), 32'd0);
    chk("t3_err_count", 32'(err_cnt - e0), 32'd1);

    // done lands exactly on the timeout expiry cycle -> accepted.
    exact_txn = 2;
    e0 = err_cnt;
    pulse_nxt();
    wait_for("t6_vld_seen", 0, 3000);
    exact_txn = -1;
    chk("t6_no_err", 32'(err_cnt - e0), 32'd0);

    // Reset while waiting for the steering pot read.
    lat_cfg = 20;
    pulse_nxt();
    for (int i = 0; i < 2000 && last_txn != 5; i++) @(negedge clk);
    chk("t5_reached_steer_rd", 32'(last_txn), 32'd5);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_async");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nxt = 1'b1;
    wait_for("t5_first_wrt", 2, 10);
    nxt = 1'b0;
    chk("t5_first_cmd", 32'(cmd), 32'h0000);
    wait_for("t5_vld_seen", 0, 2000);

    // Randomized latency/data rounds.
    for (int r = 0; r < 4; r++) begin
      lat_cfg = int'($urandom_range(1, 40));
      pulse_nxt();
      wait_for("rand_vld_seen", 0, 2000);
    end
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
